euler_solver: RTL

EULER_SOLVER -- requirements
Module: euler_solver

---
 rtl/euler_solver_if.sv | 39 +++
 rtl/euler_solver.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/euler_solver_if.sv
// Bundles the euler_solver handshake and RAM port signals.
//   master : the solver side (drives addresses, write port, status)
//   slave  : step controller plus RAM side (drives Enable and read data)
// Signals:
//   Euler_Enable            start request, level
//   Euler_End               completion, level, four-phase with Euler_Enable
//   RAM_Address_RD_A/B      read addresses; data returns one cycle later
//   RAM_Data_RD_A/B         read data
//   RAM_Address_WR          write address
//   RAM_Data_WR             write data
//   Euler_Memory_WR_Enable  one-cycle write strobe
//   Euler_Overflow          sticky saturation flag for the current run
interface euler_solver_if #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64
);
  logic                     Euler_Enable;
  logic                     Euler_End;
  logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_A;
  logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_B;
  logic [DATA_WIDTH-1:0]    RAM_Data_RD_A;
  logic [DATA_WIDTH-1:0]    RAM_Data_RD_B;
  logic [ADDRESS_WIDTH-1:0] RAM_Address_WR;
  logic [DATA_WIDTH-1:0]    RAM_Data_WR;
  logic                     Euler_Memory_WR_Enable;
  logic                     Euler_Overflow;

  modport master (
    input  Euler_Enable, RAM_Data_RD_A, RAM_Data_RD_B,
    output Euler_End, RAM_Address_RD_A, RAM_Address_RD_B,
           RAM_Address_WR, RAM_Data_WR, Euler_Memory_WR_Enable, Euler_Overflow
  );

  modport slave (
    output Euler_Enable, RAM_Data_RD_A, RAM_Data_RD_B,
    input  Euler_End, RAM_Address_RD_A, RAM_Address_RD_B,
           RAM_Address_WR, RAM_Data_WR, Euler_Memory_WR_Enable, Euler_Overflow
  );
endinterface

// File: rtl/euler_solver.sv
// One explicit Euler step: x_proc[i] = x_init[i] + h * sum_j A[i][j]*x_init[j],
// in 16-bit signed Q-format (FRAC_BITS fractional bits) with saturation.
// Ports:
//   CLK  clock, rising edge
//   RST  synchronous, active-high reset
//   bus  euler_solver_if.master (handshake, two read ports, one write port,
//        sticky overflow flag)
module euler_solver #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64,
  parameter int FRAC_BITS     = 10,
  parameter int N_ADD         = 0,
  parameter int H_ADD         = 4,
  parameter int X_PROCESS_ADD = 6,
  parameter int X_INIT_ADD    = 56,
  parameter int A_ADD         = 156
) (
  input logic            CLK,
  input logic            RST,
  euler_solver_if.master bus
);

  localparam logic [5:0]  N_MAX   = 6'd50;
  localparam logic [31:0] N_BASE  = N_ADD;
  localparam logic [31:0] H_BASE  = H_ADD;
  localparam logic [31:0] XP_BASE = X_PROCESS_ADD;
  localparam logic [31:0] XI_BASE = X_INIT_ADD;
  localparam logic [31:0] A_BASE  = A_ADD;

  typedef enum logic [2:0] {
    IDLE, RD_PARAM, CAP_PARAM, MAC, DRAIN, WRITE, DONE
  } state_t;

  state_t state, next_state;

  logic [5:0]         n_cnt, i_cnt, j_cnt;
  logic signed [15:0] h_val;
  logic signed [31:0] acc;
  logic               ovf;

  logic signed [31:0] op_a, op_b, prod_full, prod;
  logic signed [15:0] acc_s, h_s, res;
  logic signed [31:0] h_full, h_prod, sum;
  logic               wr_ovf;
  logic [12:0]        n_raw;
  logic [5:0]         n_clamp;
  logic               last_j, last_i;
  logic [31:0]        a_addr, xj_addr, xi_addr, wr_addr;

  function automatic logic sat_hit(input logic signed [31:0] v);
    return (v > 32'sd32767) || (v < -32'sd32768);
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)  return 16'sh7FFF;
    if (v < -32'sd32768) return 16'sh8000;
    return v[15:0];
  endfunction

  // Arithmetic: operands are the signed low 16 bits of each RAM word.
  always_comb begin
    op_a      = $signed({{16{bus.RAM_Data_RD_A[15]}}, bus.RAM_Data_RD_A[15:0]});
    op_b      = $signed({{16{bus.RAM_Data_RD_B[15]}}, bus.RAM_Data_RD_B[15:0]});
    prod_full = op_a * op_b;
    prod      = prod_full >>> FRAC_BITS;
    acc_s     = sat16(acc);
    h_full    = $signed({{16{h_val[15]}}, h_val}) * $signed({{16{acc_s[15]}}, acc_s});
    h_prod    = h_full >>> FRAC_BITS;
    h_s       = sat16(h_prod);
    // In WRITE, read port A carries x_init[i] requested during DRAIN.
    sum       = op_a + $signed({{16{h_s[15]}}, h_s});
    res       = sat16(sum);
    wr_ovf    = sat_hit(acc) | sat_hit(h_prod) | sat_hit(sum);
    n_raw     = bus.RAM_Data_RD_A[12:0];
    n_clamp   = (n_raw > 13'd50) ? N_MAX : n_raw[5:0];
    last_j    = (j_cnt == n_cnt - 6'd1);
    last_i    = (i_cnt == n_cnt - 6'd1);
    a_addr    = A_BASE + 32'(i_cnt) * 32'(n_cnt) + 32'(j_cnt);
    xj_addr   = XI_BASE + 32'(j_cnt);
    xi_addr   = XI_BASE + 32'(i_cnt);
    wr_addr   = XP_BASE + 32'(i_cnt);
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (bus.Euler_Enable) next_state = RD_PARAM;
      RD_PARAM:  next_state = CAP_PARAM;
      CAP_PARAM: next_state = (n_clamp == 6'd0) ? DONE : MAC;
      MAC:       if (last_j) next_state = DRAIN;
      DRAIN:     next_state = WRITE;
      WRITE:     next_state = last_i ? DONE : MAC;
      DONE:      if (!bus.Euler_Enable) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      n_cnt <= '0;
      i_cnt <= '0;
      j_cnt <= '0;
      h_val <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.Euler_Enable) ovf <= 1'b0;
        CAP_PARAM: begin
          n_cnt <= n_clamp;
          h_val <= op_b[15:0];
          i_cnt <= '0;
          j_cnt <= '0;
          acc   <= '0;
        end
        MAC: begin
          // Read data lags the address by one cycle: at j=0 nothing valid yet.
          if (j_cnt != 6'd0) acc <= acc + prod;
          j_cnt <= j_cnt + 6'd1;
        end
        DRAIN: acc <= acc + prod;
        WRITE: begin
          acc   <= '0;
          ovf   <= ovf | wr_ovf;
          j_cnt <= '0;
          if (!last_i) i_cnt <= i_cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs (Moore, zero outside the states that drive them)
  always_comb begin
    bus.Euler_End              = 1'b0;
    bus.RAM_Address_RD_A       = '0;
    bus.RAM_Address_RD_B       = '0;
    bus.RAM_Address_WR         = '0;
    bus.RAM_Data_WR            = '0;
    bus.Euler_Memory_WR_Enable = 1'b0;
    bus.Euler_Overflow         = ovf;
    unique case (state)
      RD_PARAM: begin
        bus.RAM_Address_RD_A = ADDRESS_WIDTH'(N_BASE);
        bus.RAM_Address_RD_B = ADDRESS_WIDTH'(H_BASE);
      end
      MAC: begin
        bus.RAM_Address_RD_A = ADDRESS_WIDTH'(a_addr);
        bus.RAM_Address_RD_B = ADDRESS_WIDTH'(xj_addr);
      end
      DRAIN: bus.RAM_Address_RD_A = ADDRESS_WIDTH'(xi_addr);
      WRITE: begin
        bus.RAM_Address_WR = ADDRESS_WIDTH'(wr_addr);
        bus.RAM_Data_WR    = {{(DATA_WIDTH-16){res[15]}}, res};
        // A reset arriving during WRITE must not let the RAM commit the word.
        bus.Euler_Memory_WR_Enable = !RST;
      end
      DONE: bus.Euler_End = bus.Euler_Enable;
      default: ;
    endcase
  end

endmodule
